// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
// Defaults, sweep-state encoding and lane packing macros.
`ifndef RF_PKG_MACROS
`define RF_PKG_MACROS
`define RF_RA(v, i, aw) v[(i)*(aw) +: (aw)]
`define RF_RD(v, i, dw) v[(i)*(dw) +: (dw)]
`endif

package rf_pkg;

  localparam int RF_DW = 32;
  localparam int RF_AW = 5;

  localparam logic RF_INIT = 1'b0;
  localparam logic RF_RUN  = 1'b1;

  typedef enum logic {
    ST_INIT = RF_INIT,
    ST_RUN  = RF_RUN
  } rf_state_e;

endpackage

// File: rtl/rf_init_ctrl.sv
// Post-reset clear sequencer for the register file.
// Walks every entry once, then raises ready.
module rf_init_ctrl
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_AW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  ready_o,
  output logic                  run_o,
  output logic                  sweep_we_o,
  output logic [ADDR_WIDTH-1:0] sweep_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  rf_state_e             state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready_q;

  // Sweep FSM: clear one entry per edge, finish on the last index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_q <= ST_RUN;
        ready_q <= 1'b1;
      end
    end
  end

  assign ready_o      = ready_q;
  assign run_o        = (state_q == ST_RUN);
  assign sweep_we_o   = (state_q == ST_INIT) && !rst_i;
  assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD reads, two writes.
// Port 1 wins on collisions; entry 0 always reads zero.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DW,
  parameter int ADDR_WIDTH = RF_AW,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ready,
  input  logic                         wen0,
  input  logic [ADDR_WIDTH-1:0]        waddr0,
  input  logic [DATA_WIDTH-1:0]        wdata0,
  input  logic                         wen1,
  input  logic [ADDR_WIDTH-1:0]        waddr1,
  input  logic [DATA_WIDTH-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic                  run;
  logic                  sweep_we;
  logic [ADDR_WIDTH-1:0] sweep_addr;

  logic                  wv0;
  logic                  wv1;
  logic                  wr0_eff;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  rf_init_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ctrl (
    .clk_i       (clk),
    .rst_i       (rst),
    .ready_o     (ready),
    .run_o       (run),
    .sweep_we_o  (sweep_we),
    .sweep_addr_o(sweep_addr)
  );

  assign wv0 = run && !rst && wen0 && (waddr0 != '0);
  assign wv1 = run && !rst && wen1 && (waddr1 != '0);
  assign wr0_eff = wv0 && !(wv1 && (waddr1 == waddr0));

  // Storage: sweep clears, otherwise both write ports land.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_addr] <= '0;
    end else begin
      if (wv1) mem_q[waddr1] <= wdata1;
      if (wr0_eff) mem_q[waddr0] <= wdata0;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;

    assign ra = `RF_RA(raddr, i, ADDR_WIDTH);

    // Lane read: zero gating, then optional same-cycle bypass.
    always_comb begin
      rd = '0;
      if (run && (ra != '0)) begin
        rd = mem_q[ra];
        if (BYPASS != 0) begin
          if (wv0 && (waddr0 == ra)) rd = wdata0;
          if (wv1 && (waddr1 == ra)) rd = wdata1;
        end
      end
    end

    assign `RF_RD(rdata, i, DATA_WIDTH) = rd;
  end

endmodule
